// File: rtl/eth_udp_tx_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : eth_udp_tx_sched_if
//  Purpose  : Scheduler <-> UDP/GMII transmit engine bundle: start pulse,
//             frame length/ports, payload read strobe/data and frame-done.
//  Revision : 1.0 - initial release
// ============================================================================
interface eth_udp_tx_sched_if;
  logic        tx_en_pulse;
  logic [15:0] data_length;
  logic [15:0] dst_port;
  logic [15:0] src_port;
  logic        payload_req;
  logic [7:0]  payload_dat;
  logic        tx_done;

  // Scheduler side
  modport master (
    output tx_en_pulse, data_length, dst_port, src_port, payload_dat,
    input  payload_req, tx_done
  );

  // Transmit engine side
  modport slave (
    input  tx_en_pulse, data_length, dst_port, src_port, payload_dat,
    output payload_req, tx_done
  );
endinterface
`default_nettype wire

// File: rtl/eth_udp_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : eth_udp_tx_sched
//  Purpose  : Round-robin scheduler sharing one UDP/GMII transmit engine
//             among NUM_CH payload sources. Latches length/ports, holds them
//             through the engine's length pipeline, fires the start pulse,
//             routes payload reads, waits for done and enforces the IFG.
//  Revision : 1.0 - initial release
// ============================================================================
module eth_udp_tx_sched #(
  parameter int NUM_CH       = 4,
  parameter int SETUP_CYCLES = 3,
  parameter int IFG_CYCLES   = 16,
  parameter int MAX_LEN      = 1472,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic                        clk125m,
  input  logic                        reset_n,
  input  logic [NUM_CH-1:0]           ch_req,
  input  logic [16*NUM_CH-1:0]        ch_len,
  input  logic [16*NUM_CH-1:0]        ch_dst_port,
  input  logic [16*NUM_CH-1:0]        ch_src_port,
  input  logic [8*NUM_CH-1:0]         ch_payload_dat,
  output logic [NUM_CH-1:0]           ch_payload_req,
  output logic [NUM_CH-1:0]           ch_grant,
  output logic [NUM_CH-1:0]           ch_done,
  output logic [NUM_CH-1:0]           ch_reject,
  eth_udp_tx_sched_if.master          eng,
  output logic                        busy,
  output logic [$clog2(NUM_CH)-1:0]   cur_ch,
  output logic                        err_timeout
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int EXT_W = IDX_W + 1;
  localparam int CNT_W = $clog2(DONE_TIMEOUT + IFG_CYCLES + SETUP_CYCLES);

  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] IFG_LAST     = CNT_W'(IFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(DONE_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_IFG    = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] sel;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] ptr_nxt;
  logic [EXT_W-1:0] cand_ext;
  logic [IDX_W-1:0] cand;
  logic             len_ok;

  logic [15:0] len_a [NUM_CH];
  logic [15:0] dst_a [NUM_CH];
  logic [15:0] src_a [NUM_CH];
  logic [7:0]  dat_a [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign len_a[gi] = ch_len[16*gi +: 16];
    assign dst_a[gi] = ch_dst_port[16*gi +: 16];
    assign src_a[gi] = ch_src_port[16*gi +: 16];
    assign dat_a[gi] = ch_payload_dat[8*gi +: 8];
  end

  function automatic logic [NUM_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Round-robin pick: scan from rr_ptr upward with wrap; descending loop
  // lets the closest requester to rr_ptr overwrite the others.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_ext  = '0;
    cand      = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand_ext = {1'b0, rr_ptr} + EXT_W'(k);
      if (cand_ext >= EXT_W'(NUM_CH)) cand_ext = cand_ext - EXT_W'(NUM_CH);
      cand = cand_ext[IDX_W-1:0];
      if (ch_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign ptr_nxt = (win_idx == IDX_W'(NUM_CH - 1)) ? '0 : win_idx + IDX_W'(1);
  assign len_ok  = (len_a[win_idx] != 16'd0) && (len_a[win_idx] <= 16'(MAX_LEN));

  // State register
  always_ff @(posedge clk125m) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; tx_done wins over a coincident timeout
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (win_found && len_ok)                 state_nxt = S_SETUP;
      S_SETUP:  if (cnt == SETUP_LAST)                   state_nxt = S_LAUNCH;
      S_LAUNCH:                                          state_nxt = S_WAIT;
      S_WAIT:   if (eng.tx_done || cnt == TIMEOUT_LAST)  state_nxt = S_IFG;
      S_IFG:    if (cnt == IFG_LAST)                     state_nxt = S_IDLE;
      default:                                           state_nxt = S_IDLE;
    endcase
  end

  // Frame bookkeeping: arbitration pointer, latched frame parameters,
  // phase counter and the registered one-cycle status pulses
  always_ff @(posedge clk125m) begin
    if (!reset_n) begin
      rr_ptr          <= '0;
      sel             <= '0;
      cnt             <= '0;
      cur_ch          <= '0;
      ch_done         <= '0;
      ch_reject       <= '0;
      err_timeout     <= 1'b0;
      eng.data_length <= '0;
      eng.dst_port    <= '0;
      eng.src_port    <= '0;
    end else begin
      ch_done     <= '0;
      ch_reject   <= '0;
      err_timeout <= 1'b0;
      cnt         <= (state_nxt != state || state == S_IDLE) ? '0 : cnt + CNT_W'(1);
      if (state == S_IDLE && win_found) begin
        rr_ptr <= ptr_nxt;
        if (len_ok) begin
          sel             <= win_idx;
          eng.data_length <= len_a[win_idx];
          eng.dst_port    <= dst_a[win_idx];
          eng.src_port    <= src_a[win_idx];
        end else begin
          ch_reject <= onehot(win_idx);
        end
      end
      if (state == S_SETUP && state_nxt == S_LAUNCH) cur_ch <= sel;
      if (state == S_WAIT && state_nxt == S_IFG) begin
        ch_done     <= onehot(sel);
        err_timeout <= !eng.tx_done;
      end
    end
  end

  // State-decoded outputs; payload path is only connected during WAIT_DONE
  always_comb begin
    busy            = (state != S_IDLE);
    eng.tx_en_pulse = (state == S_LAUNCH);
    ch_grant        = (state == S_LAUNCH) ? onehot(sel) : '0;
    ch_payload_req  = '0;
    eng.payload_dat = 8'h00;
    if (state == S_WAIT) begin
      ch_payload_req  = eng.payload_req ? onehot(sel) : '0;
      eng.payload_dat = dat_a[sel];
    end
  end

endmodule
`default_nettype wire
